// File: rtl/dual_issue_pkg.sv
// Shared opcodes, instruction class and decode helpers
// for the dual-issue scheduler (no ports; package only).
package dual_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic {
    CLS_ALU,
    CLS_MEM
  } cls_e;

  typedef struct packed {
    logic       rs_v;
    logic [4:0] rs;
    logic       rt_v;
    logic [4:0] rt;
  } srcs_t;

  function automatic cls_e get_cls(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    get_cls = CLS_ALU;
    if (op == OP_LW || op == OP_SW)
      get_cls = CLS_MEM;
  endfunction

  function automatic logic is_branch(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    is_branch = (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // Returns 0 when the word writes no register.
  function automatic logic [4:0] get_dest(input logic [31:0] inst);
    logic [5:0] op;
    op = inst[31:26];
    get_dest = 5'd0;
    unique case (1'b1)
      op == OP_RTYPE: get_dest = inst[15:11];
      op == OP_ADDI,
      op == OP_LW:    get_dest = inst[20:16];
      default:        get_dest = 5'd0;
    endcase
  endfunction

  function automatic srcs_t get_srcs(input logic [31:0] inst);
    logic [5:0] op;
    srcs_t s;
    op   = inst[31:26];
    s.rs = inst[25:21];
    s.rt = inst[20:16];
    s.rs_v = 1'b0;
    s.rt_v = 1'b0;
    unique case (1'b1)
      op == OP_RTYPE,
      op == OP_BEQ,
      op == OP_BNE,
      op == OP_SW: begin
        s.rs_v = 1'b1;
        s.rt_v = 1'b1;
      end
      op == OP_ADDI,
      op == OP_LW:   s.rs_v = 1'b1;
      default: ;
    endcase
    get_srcs = s;
  endfunction

endpackage

// File: rtl/dis_scoreboard.sv
// Per-register writeback countdown; busy while nonzero.
// Ports: advance, two load ports, four query regs -> busy[3:0].
module dis_scoreboard #(
  parameter int WB_DIST = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       ld0_en,
  input  logic [4:0] ld0_reg,
  input  logic       ld1_en,
  input  logic [4:0] ld1_reg,
  input  logic [4:0] q0,
  input  logic [4:0] q1,
  input  logic [4:0] q2,
  input  logic [4:0] q3,
  output logic [3:0] busy
);

  localparam logic [1:0] LOAD = 2'(WB_DIST);

  logic [1:0] cnt_q [32];

  // $0 is never loaded, so it always reads idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        cnt_q[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if ((ld0_en && ld0_reg == 5'(i)) ||
            (ld1_en && ld1_reg == 5'(i)))
          cnt_q[i] <= LOAD;
        else if (advance && cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - 2'd1;
      end
    end
  end

  assign busy[0] = cnt_q[q0] != '0;
  assign busy[1] = cnt_q[q1] != '0;
  assign busy[2] = cnt_q[q2] != '0;
  assign busy[3] = cnt_q[q3] != '0;

endmodule

// File: rtl/dual_issue_sched.sv
// In-order pairing scheduler: fetch FIFO -> {ALU slot0, MEM slot1}.
// Ports: fetch valid/ready/inst, flush, iss valid/ready/inst0/inst1.
module dual_issue_sched
  import dual_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WB_DIST = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_inst,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [31:0] iss_inst0,
  output logic [31:0] iss_inst1
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   cnt_q;
  logic          hold_q;
  logic          hold_pair_q;

  logic [31:0] h0, h1;
  logic        h0_v, h1_v;
  logic        h0_ok, h1_ok;
  logic        h0_alu, h1_alu;
  srcs_t       s0, s1;
  logic [4:0]  d0, d1;
  logic [3:0]  busy;
  logic        rd_d0, pair_ok, pair_sel;
  logic        fire, push, ld0_en, ld1_en;
  logic [1:0]  pops;

  assign h0     = mem_q[head_q];
  assign h1     = mem_q[head_q + AW'(1)];
  assign h0_v   = cnt_q != '0;
  assign h1_v   = cnt_q > (AW+1)'(1);
  assign s0     = get_srcs(h0);
  assign s1     = get_srcs(h1);
  assign d0     = get_dest(h0);
  assign d1     = get_dest(h1);
  assign h0_alu = get_cls(h0) == CLS_ALU;
  assign h1_alu = get_cls(h1) == CLS_ALU;

  assign h0_ok = !(s0.rs_v && busy[0]) &&
                 !(s0.rt_v && busy[1]);
  assign h1_ok = !(s1.rs_v && busy[2]) &&
                 !(s1.rt_v && busy[3]);

  assign rd_d0 = (d0 != '0) &&
                 ((s1.rs_v && s1.rs == d0) ||
                  (s1.rt_v && s1.rt == d0));

  assign pair_ok = h1_v && h1_ok &&
                   (h0_alu != h1_alu) &&
                   !is_branch(h0) && !rd_d0 &&
                   !(d0 != '0 && d0 == d1);

  // A stalled bundle keeps its pairing even if a
  // pairable word lands behind it meanwhile.
  assign pair_sel = hold_q ? hold_pair_q : pair_ok;

  assign iss_valid   = h0_v && h0_ok && !flush;
  assign fire        = iss_valid && iss_ready;
  assign fetch_ready = cnt_q < FULL;
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pops        = !fire ? 2'd0 :
                       pair_sel ? 2'd2 : 2'd1;
  assign ld0_en      = fire && d0 != '0;
  assign ld1_en      = fire && pair_sel && d1 != '0;

  dis_scoreboard #(
    .WB_DIST(WB_DIST)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(iss_ready),
    .ld0_en (ld0_en),
    .ld0_reg(d0),
    .ld1_en (ld1_en),
    .ld1_reg(d1),
    .q0     (s0.rs),
    .q1     (s0.rt),
    .q2     (s1.rs),
    .q3     (s1.rt),
    .busy   (busy)
  );

  always_ff @(posedge clk) begin
    if (push)
      mem_q[tail_q] <= fetch_inst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= 1'b0;
      hold_pair_q <= 1'b0;
    end else begin
      hold_q      <= iss_valid && !iss_ready;
      hold_pair_q <= pair_sel;
      if (flush) begin
        head_q <= tail_q;
        cnt_q  <= '0;
      end else begin
        if (push)
          tail_q <= tail_q + AW'(1);
        head_q <= head_q + AW'(pops);
        cnt_q  <= cnt_q + (AW+1)'(push)
                        - (AW+1)'(pops);
      end
    end
  end

  always_comb begin
    iss_inst0 = NOP_WORD;
    iss_inst1 = NOP_WORD;
    unique case (1'b1)
      !iss_valid: ;
      iss_valid && pair_sel && h0_alu: begin
        iss_inst0 = h0;
        iss_inst1 = h1;
      end
      iss_valid && pair_sel && !h0_alu: begin
        iss_inst0 = h1;
        iss_inst1 = h0;
      end
      iss_valid && !pair_sel && h0_alu:
        iss_inst0 = h0;
      iss_valid && !pair_sel && !h0_alu:
        iss_inst1 = h0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dual_issue_sched.sv
// Directed bench for dual_issue_sched.
// Drives at posedge+1, checks at posedge+2.
module tb_dual_issue_sched;

  localparam logic [31:0] ADD3   = 32'h00221820;
  localparam logic [31:0] ADD9   = 32'h01084820;
  localparam logic [31:0] ADD11  = 32'h00225820;
  localparam logic [31:0] ADD7   = 32'h00433820;
  localparam logic [31:0] ADDI1  = 32'h20010001;
  localparam logic [31:0] ADDI4  = 32'h20040008;
  localparam logic [31:0] ADDI8  = 32'h20080001;
  localparam logic [31:0] LW5_4  = 32'h8C850000;
  localparam logic [31:0] LW7_1  = 32'h8C270000;
  localparam logic [31:0] LW10   = 32'h8C2A0000;
  localparam logic [31:0] LW12   = 32'h8C4C0000;
  localparam logic [31:0] SW3_6  = 32'hACC30000;
  localparam logic [31:0] SW13   = 32'hAC6D0000;
  localparam logic [31:0] BEQ12  = 32'h10220004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_inst;
  logic        fetch_ready;
  logic        flush;
  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_inst0;
  logic [31:0] iss_inst1;

  int checks   = 0;
  int failures = 0;

  dual_issue_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_valid(fetch_valid),
    .fetch_inst (fetch_inst),
    .fetch_ready(fetch_ready),
    .flush      (flush),
    .iss_valid  (iss_valid),
    .iss_ready  (iss_ready),
    .iss_inst0  (iss_inst0),
    .iss_inst1  (iss_inst1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic bund(input string tag,
                      input logic v,
                      input logic [31:0] i0,
                      input logic [31:0] i1);
    chk({tag, "_valid"}, 32'(iss_valid), 32'(v));
    chk({tag, "_inst0"}, iss_inst0, i0);
    chk({tag, "_inst1"}, iss_inst1, i1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_valid = 1'b0;
    fetch_inst  = '0;
    flush       = 1'b0;
    iss_ready   = 1'b0;
    #3;
    bund("rst", 1'b0, 32'h0, 32'h0);
    chk("rst_fready", 32'(fetch_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    #1;
    bund("rst_rel", 1'b0, 32'h0, 32'h0);

    // intra-pair RAW: addi alone, lw 3 ready-cycles later
    step();
    iss_ready = 1'b1;
    fetch_valid = 1'b1;
    fetch_inst = ADDI4;
    #1;
    chk("t3_empty", 32'(iss_valid), 32'd0);
    step();
    fetch_inst = LW5_4;
    #1;
    bund("t3_addi", 1'b1, ADDI4, 32'h0);
    step();
    fetch_valid = 1'b0;
    #1;
    bund("t3_wait1", 1'b0, 32'h0, 32'h0);
    step();
    #1;
    bund("t3_wait2", 1'b0, 32'h0, 32'h0);
    step();
    #1;
    bund("t3_wait3", 1'b0, 32'h0, 32'h0);
    step();
    #1;
    bund("t3_lw", 1'b1, 32'h0, LW5_4);
    step();
    #1;
    bund("t3_done", 1'b0, 32'h0, 32'h0);
    idle(3);

    // independent pair behind a blocked head
    step();
    fetch_valid = 1'b1;
    fetch_inst = ADDI1;
    step();
    fetch_inst = ADD3;
    #1;
    bund("t2_addi", 1'b1, ADDI1, 32'h0);
    step();
    fetch_inst = LW5_4;
    #1;
    bund("t2_blk1", 1'b0, 32'h0, 32'h0);
    step();
    fetch_valid = 1'b0;
    #1;
    bund("t2_blk2", 1'b0, 32'h0, 32'h0);
    step();
    #1;
    bund("t2_blk3", 1'b0, 32'h0, 32'h0);
    step();
    #1;
    bund("t2_pair", 1'b1, ADD3, LW5_4);
    step();
    #1;
    bund("t2_done", 1'b0, 32'h0, 32'h0);
    idle(3);

    // WAW: lw $7 then add $7 never pair
    step();
    fetch_valid = 1'b1;
    fetch_inst = ADDI1;
    step();
    fetch_inst = LW7_1;
    #1;
    bund("t6_addi", 1'b1, ADDI1, 32'h0);
    step();
    fetch_inst = ADD7;
    #1;
    bund("t6_blk", 1'b0, 32'h0, 32'h0);
    step();
    fetch_valid = 1'b0;
    step();
    step();
    #1;
    bund("t6_lw", 1'b1, 32'h0, LW7_1);
    step();
    #1;
    bund("t6_add", 1'b1, ADD7, 32'h0);
    step();
    #1;
    bund("t6_done", 1'b0, 32'h0, 32'h0);
    idle(3);

    // branch issues alone; flush drops the sw
    step();
    fetch_valid = 1'b1;
    fetch_inst = ADDI1;
    step();
    fetch_inst = BEQ12;
    step();
    fetch_inst = SW3_6;
    step();
    fetch_valid = 1'b0;
    step();
    step();
    #1;
    bund("t4_beq", 1'b1, BEQ12, 32'h0);
    step();
    iss_ready = 1'b0;
    #1;
    bund("t4_sw", 1'b1, 32'h0, SW3_6);
    flush = 1'b1;
    #1;
    bund("t4_flush", 1'b0, 32'h0, 32'h0);
    step();
    flush = 1'b0;
    iss_ready = 1'b1;
    #1;
    bund("t4_gone", 1'b0, 32'h0, 32'h0);
    chk("t4_fready", 32'(fetch_ready), 32'd1);
    // flush on an empty queue also blocks a push
    step();
    flush = 1'b1;
    fetch_valid = 1'b1;
    fetch_inst = ADD3;
    #1;
    chk("t4_eflush_v", 32'(iss_valid), 32'd0);
    step();
    flush = 1'b0;
    fetch_valid = 1'b0;
    #1;
    bund("t4_nopush", 1'b0, 32'h0, 32'h0);
    idle(3);

    // backpressure, full queue, frozen scoreboard
    step();
    fetch_valid = 1'b1;
    fetch_inst = ADDI8;
    step();
    fetch_inst = ADD9;
    #1;
    bund("t5_addi", 1'b1, ADDI8, 32'h0);
    step();
    iss_ready = 1'b0;
    fetch_inst = LW10;
    step();
    fetch_inst = ADD11;
    step();
    fetch_inst = LW12;
    #1;
    chk("t5_fr3", 32'(fetch_ready), 32'd1);
    step();
    fetch_inst = SW13;
    #1;
    chk("t5_full", 32'(fetch_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      bund("t5_frozen", 1'b0, 32'h0, 32'h0);
      chk("t5_frozen_fr", 32'(fetch_ready), 32'd0);
    end
    step();
    iss_ready = 1'b1;
    #1;
    bund("t5_r0", 1'b0, 32'h0, 32'h0);
    step();
    #1;
    bund("t5_r1", 1'b0, 32'h0, 32'h0);
    step();
    #1;
    bund("t5_r2", 1'b0, 32'h0, 32'h0);
    step();
    iss_ready = 1'b0;
    #1;
    bund("t5_pair", 1'b1, ADD9, LW10);
    step();
    #1;
    bund("t5_hold", 1'b1, ADD9, LW10);
    chk("t5_hold_fr", 32'(fetch_ready), 32'd0);
    step();
    iss_ready = 1'b1;
    #1;
    bund("t5_fire", 1'b1, ADD9, LW10);
    chk("t5_popfull", 32'(fetch_ready), 32'd0);
    step();
    #1;
    bund("t5_pair2", 1'b1, ADD11, LW12);
    chk("t5_fr_open", 32'(fetch_ready), 32'd1);
    step();
    fetch_valid = 1'b0;
    #1;
    bund("t5_sw", 1'b1, 32'h0, SW13);
    step();
    #1;
    bund("t5_done", 1'b0, 32'h0, 32'h0);
    idle(3);

    // asynchronous reset mid-stream
    step();
    iss_ready = 1'b0;
    fetch_valid = 1'b1;
    fetch_inst = ADD3;
    step();
    fetch_inst = LW5_4;
    #1;
    bund("t1_pre", 1'b1, ADD3, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    bund("t1_rst", 1'b0, 32'h0, 32'h0);
    chk("t1_rst_fr", 32'(fetch_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    fetch_valid = 1'b0;
    iss_ready = 1'b1;
    #1;
    bund("t1_empty", 1'b0, 32'h0, 32'h0);
    chk("t1_fr", 32'(fetch_ready), 32'd1);
    step();
    #1;
    bund("t1_empty2", 1'b0, 32'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
